// File: rtl/pwm_multi_if.sv
// Control, duty-write and output bundle for pwm_multi.
// Ports: ena/prescale/center/wr_en/wr_ch/wr_duty run controller -> PWM; out/period_start run PWM -> controller.
// The master modport is the controller side and the slave modport is the PWM block.
interface pwm_multi_if #(
    parameter int N          = 4,
    parameter int CHANNELS   = 4,
    parameter int PRESCALE_W = 8
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                  ena;
    logic [PRESCALE_W-1:0] prescale;
    logic                  center;
    logic                  wr_en;
    logic [CH_W-1:0]       wr_ch;
    logic [N-1:0]          wr_duty;
    logic [CHANNELS-1:0]   out;
    logic                  period_start;

    modport master (
        output ena, prescale, center, wr_en, wr_ch, wr_duty,
        input  out, period_start
    );

    modport slave (
        input  ena, prescale, center, wr_en, wr_ch, wr_duty,
        output out, period_start
    );
endinterface

// File: rtl/pwm_multi.sv
// Multi-channel PWM: one shared prescaled counter (edge- or center-aligned) with double-buffered per-channel duties.
// Latency: out/period_start are registered one clock after the counter state they reflect; duty writes land in the shadow the same cycle.
// Backpressure: none; writes are always accepted and writes to a channel index past the last channel are dropped.
// Ports: clk, rst (async, active-high); bus (slave modport) carries ena, prescale, center, wr_en/wr_ch/wr_duty, out, period_start.
module pwm_multi #(
    parameter int N          = 4,
    parameter int CHANNELS   = 4,
    parameter int PRESCALE_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    pwm_multi_if.slave bus
);
    localparam int               CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CH_W:0]    CH_LIM  = (CH_W + 1)'(CHANNELS);
    localparam logic [N-1:0]     CNT_MAX = '1;

    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [N-1:0]          cnt_q, cnt_d;
    logic                  dir_dn_q, dir_dn_d;   // center mode only: 1 while counting down
    logic                  mode_q, mode_d;       // 0 edge-aligned, 1 center-aligned
    logic [N-1:0]          shadow_q [CHANNELS];
    logic [N-1:0]          shadow_d [CHANNELS];
    logic [N-1:0]          active_q [CHANNELS];
    logic [N-1:0]          active_d [CHANNELS];
    logic [CHANNELS-1:0]   out_q, out_d;
    logic                  period_start_q, period_start_d;

    logic tick;
    logic bnd;      // counter is about to return to 0: end of the current period
    logic wr_ok;
    logic reload;   // duties and mode are taken over at a boundary or continuously while disabled

    always_comb begin
        tick   = bus.ena && (presc_q >= bus.prescale);
        bnd    = tick && (mode_q ? (dir_dn_q && (cnt_q == N'(1))) : (cnt_q == CNT_MAX));
        wr_ok  = bus.wr_en && ({1'b0, bus.wr_ch} < CH_LIM);
        reload = bnd || !bus.ena;

        // Shadow is updated first so a write in a reload cycle goes straight into the active duty.
        for (int i = 0; i < CHANNELS; i++) begin
            shadow_d[i] = shadow_q[i];
            if (wr_ok && (bus.wr_ch == CH_W'(i))) begin
                shadow_d[i] = bus.wr_duty;
            end
            active_d[i] = reload ? shadow_d[i] : active_q[i];
            out_d[i]    = bus.ena && (active_q[i] > cnt_q);
        end

        mode_d         = reload ? bus.center : mode_q;
        period_start_d = bnd;

        presc_d  = presc_q;
        cnt_d    = cnt_q;
        dir_dn_d = dir_dn_q;
        if (!bus.ena) begin
            presc_d  = '0;
            cnt_d    = '0;
            dir_dn_d = 1'b0;
        end else if (!tick) begin
            presc_d = presc_q + 1'b1;
        end else begin
            presc_d = '0;
            if (bnd) begin
                // Both modes restart from 0 counting up, so a mode change here is seamless.
                cnt_d    = '0;
                dir_dn_d = 1'b0;
            end else if (!mode_q) begin
                cnt_d = cnt_q + 1'b1;
            end else if (!dir_dn_q) begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d    = cnt_q - 1'b1;
                    dir_dn_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q        <= '0;
            cnt_q          <= '0;
            dir_dn_q       <= 1'b0;
            mode_q         <= 1'b0;
            out_q          <= '0;
            period_start_q <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            presc_q        <= presc_d;
            cnt_q          <= cnt_d;
            dir_dn_q       <= dir_dn_d;
            mode_q         <= mode_d;
            out_q          <= out_d;
            period_start_q <= period_start_d;
            shadow_q       <= shadow_d;
            active_q       <= active_d;
        end
    end

    assign bus.out          = out_q;
    assign bus.period_start = period_start_q;
endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi (N=4, CHANNELS=4) plus a 5-channel build for the out-of-range write.
// The reference model tracks the position inside the period and derives the count from it.
// Scenario tasks run in sequence and compare inline.
module tb_pwm_multi;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pwm_multi_if #(.N(4), .CHANNELS(4), .PRESCALE_W(8)) bus ();
    pwm_multi_if #(.N(4), .CHANNELS(5), .PRESCALE_W(8)) b5 ();

    pwm_multi #(.N(4), .CHANNELS(4), .PRESCALE_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    pwm_multi #(.N(4), .CHANNELS(5), .PRESCALE_W(8)) dut5 (.clk(clk), .rst(rst), .bus(b5));

    int tests = 0;
    int fails = 0;

    // reference model state
    int   m_pos, m_sub;
    bit   m_mode;
    int   m_sh [4];
    int   m_act[4];
    logic [3:0] exp_out;
    logic       exp_ps;

    // observation statistics
    int   cyc_diff, nstep, ps_cnt, ps_first;
    int   hi[4];
    logic [63:0] pat0;

    task automatic model_reset();
        m_pos = 0; m_sub = 0; m_mode = 1'b0;
        for (int i = 0; i < 4; i++) begin m_sh[i] = 0; m_act[i] = 0; end
    endtask

    task automatic clr();
        nstep = 0; ps_cnt = 0; ps_first = 0; pat0 = '0;
        for (int i = 0; i < 4; i++) hi[i] = 0;
    endtask

    // Advance one clock: predict the registered outputs from the model, then observe the DUT.
    task automatic step();
        int per, c;
        bit tk, b;
        per = m_mode ? 30 : 16;
        c   = (m_pos > 15) ? per - m_pos : m_pos;
        tk  = bus.ena && (m_sub >= int'(bus.prescale));
        b   = tk && (m_pos == per - 1);
        for (int i = 0; i < 4; i++) exp_out[i] = bus.ena && (m_act[i] > c);
        exp_ps = b;
        if (bus.wr_en) m_sh[bus.wr_ch] = int'(bus.wr_duty);
        if (!bus.ena) begin
            m_pos = 0; m_sub = 0; m_act = m_sh; m_mode = bus.center;
        end else if (!tk) begin
            m_sub++;
        end else begin
            m_sub = 0;
            if (b) begin m_pos = 0; m_act = m_sh; m_mode = bus.center; end
            else m_pos++;
        end
        @(posedge clk); #1;
        nstep++;
        if (bus.out !== exp_out || bus.period_start !== exp_ps) cyc_diff++;
        for (int i = 0; i < 4; i++) if (bus.out[i] === 1'b1) hi[i]++;
        pat0 = {pat0[62:0], bus.out[0]};
        if (bus.period_start === 1'b1) begin
            ps_cnt++;
            if (ps_first == 0) ps_first = nstep;
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic write_step(input int ch, input int d);
        bus.wr_en = 1'b1; bus.wr_ch = 2'(ch); bus.wr_duty = 4'(d);
        step();
        bus.wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.ena = 0; bus.prescale = 0; bus.center = 0; bus.wr_en = 0; bus.wr_ch = 0; bus.wr_duty = 0;
        b5.ena = 0; b5.prescale = 0; b5.center = 0; b5.wr_en = 0; b5.wr_ch = 0; b5.wr_duty = 0;
        #3;
        tests++; if (bus.out !== 4'b0000) begin fails++; $display("FAIL reset_out: got %b want 0000", bus.out); end
        tests++; if (bus.period_start !== 1'b0) begin fails++; $display("FAIL reset_ps: got %b want 0", bus.period_start); end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        cyc_diff = 0;
    endtask

    task automatic test_edge_duty();
        write_step(0, 0); write_step(1, 5); write_step(2, 15); write_step(3, 8);
        bus.ena = 1'b1;
        clr(); run(32);
        tests++; if (hi[0] != 0)  begin fails++; $display("FAIL edge_ch0_high: got %0d want 0", hi[0]); end
        tests++; if (hi[1] != 10) begin fails++; $display("FAIL edge_ch1_high: got %0d want 10", hi[1]); end
        tests++; if (hi[2] != 30) begin fails++; $display("FAIL edge_ch2_high: got %0d want 30", hi[2]); end
        tests++; if (hi[3] != 16) begin fails++; $display("FAIL edge_ch3_high: got %0d want 16", hi[3]); end
        tests++; if (ps_cnt != 2 || ps_first != 16) begin fails++; $display("FAIL edge_period_start: got %0d pulses first at %0d want 2 first at 16", ps_cnt, ps_first); end
        tests++; if (cyc_diff != 0) begin fails++; $display("FAIL edge_model: got %0d differing cycles want 0", cyc_diff); end
    endtask

    task automatic test_double_buffer();
        cyc_diff = 0;
        write_step(1, 3); run(15);
        clr(); run(6); write_step(1, 12); run(9);
        tests++; if (hi[1] != 3) begin fails++; $display("FAIL dbuf_current: got %0d want 3", hi[1]); end
        clr(); run(16);
        tests++; if (hi[1] != 12) begin fails++; $display("FAIL dbuf_next: got %0d want 12", hi[1]); end
        clr(); run(15); write_step(1, 7);
        tests++; if (hi[1] != 12) begin fails++; $display("FAIL dbuf_b_current: got %0d want 12", hi[1]); end
        clr(); run(16);
        tests++; if (hi[1] != 7) begin fails++; $display("FAIL dbuf_b_next: got %0d want 7", hi[1]); end
        tests++; if (cyc_diff != 0) begin fails++; $display("FAIL dbuf_model: got %0d differing cycles want 0", cyc_diff); end
    endtask

    task automatic test_center();
        logic [29:0] want_pat;
        want_pat = 30'h3C000007;
        cyc_diff = 0;
        bus.center = 1'b1;
        run(15); write_step(0, 4);
        clr(); run(30);
        tests++; if (hi[0] != 7) begin fails++; $display("FAIL center_ch0_high: got %0d want 7", hi[0]); end
        tests++; if (hi[2] != 29) begin fails++; $display("FAIL center_ch2_high: got %0d want 29", hi[2]); end
        tests++; if (pat0[29:0] !== want_pat) begin fails++; $display("FAIL center_pattern: got %h want %h", pat0[29:0], want_pat); end
        tests++; if (ps_cnt != 1 || ps_first != 30) begin fails++; $display("FAIL center_period: got %0d pulses first at %0d want 1 at 30", ps_cnt, ps_first); end
        clr(); run(10); bus.center = 1'b0; run(20);
        tests++; if (ps_first != 30 || hi[0] != 7) begin fails++; $display("FAIL center_toggle_hold: got ps at %0d high %0d want 30 and 7", ps_first, hi[0]); end
        clr(); run(16);
        tests++; if (ps_first != 16 || hi[0] != 4) begin fails++; $display("FAIL center_toggle_apply: got ps at %0d high %0d want 16 and 4", ps_first, hi[0]); end
        tests++; if (cyc_diff != 0) begin fails++; $display("FAIL center_model: got %0d differing cycles want 0", cyc_diff); end
    endtask

    task automatic test_prescale();
        cyc_diff = 0;
        bus.prescale = 8'd2;
        bus.ena = 1'b0; write_step(0, 5); bus.ena = 1'b1;
        clr(); run(48);
        tests++; if (hi[0] != 15) begin fails++; $display("FAIL presc_ch0_high: got %0d want 15", hi[0]); end
        tests++; if (hi[3] != 24) begin fails++; $display("FAIL presc_ch3_high: got %0d want 24", hi[3]); end
        tests++; if (ps_cnt != 1 || ps_first != 48) begin fails++; $display("FAIL presc_period: got %0d pulses first at %0d want 1 at 48", ps_cnt, ps_first); end
        bus.prescale = 8'd7; run(5);
        tests++; if (dut.cnt_q !== 4'd0) begin fails++; $display("FAIL presc_hold_cnt: got %0d want 0", dut.cnt_q); end
        bus.prescale = 8'd1; step();
        tests++; if (dut.cnt_q !== 4'd1) begin fails++; $display("FAIL presc_drop_tick: got %0d want 1", dut.cnt_q); end
        bus.prescale = 8'd0;
        tests++; if (cyc_diff != 0) begin fails++; $display("FAIL presc_model: got %0d differing cycles want 0", cyc_diff); end
    endtask

    task automatic test_disable();
        int bad5;
        cyc_diff = 0; bad5 = 0;
        run(6);
        tests++; if (bus.out[2] !== 1'b1) begin fails++; $display("FAIL dis_before: got %b want 1", bus.out[2]); end
        bus.ena = 1'b0; step();
        tests++; if (bus.out !== 4'b0000) begin fails++; $display("FAIL dis_out: got %b want 0000", bus.out); end
        tests++; if (dut.cnt_q !== 4'd0) begin fails++; $display("FAIL dis_cnt: got %0d want 0", dut.cnt_q); end
        write_step(3, 2);
        b5.wr_en = 1'b1; b5.wr_ch = 3'd5; b5.wr_duty = 4'd9;
        clr(); step(); run(2);
        b5.wr_en = 1'b0;
        tests++; if (hi[2] != 0) begin fails++; $display("FAIL dis_quiet: got %0d high cycles want 0", hi[2]); end
        bus.ena = 1'b1; b5.ena = 1'b1;
        clr();
        repeat (16) begin
            step();
            if (b5.out !== 5'b00000) bad5++;
        end
        tests++; if (ps_first != 16 || ps_cnt != 1) begin fails++; $display("FAIL reen_no_pulse: got first at %0d count %0d want 16 and 1", ps_first, ps_cnt); end
        tests++; if (hi[3] != 2) begin fails++; $display("FAIL reen_new_duty: got %0d want 2", hi[3]); end
        tests++; if (bad5 != 0) begin fails++; $display("FAIL wr_ch_out_of_range: got %0d high cycles want 0", bad5); end
        tests++; if (cyc_diff != 0) begin fails++; $display("FAIL dis_model: got %0d differing cycles want 0", cyc_diff); end
    endtask

    task automatic test_reset_mid();
        cyc_diff = 0;
        bus.ena = 1'b0;
        write_step(0, 15); write_step(1, 15); write_step(2, 15); write_step(3, 15);
        bus.ena = 1'b1;
        run(5);
        tests++; if (bus.out !== 4'b1111) begin fails++; $display("FAIL rstmid_before: got %b want 1111", bus.out); end
        #2 rst = 1'b1;
        #1;
        tests++; if (bus.out !== 4'b0000 || bus.period_start !== 1'b0) begin fails++; $display("FAIL rstmid_async: got %b/%b want 0000/0", bus.out, bus.period_start); end
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        tests++; if (dut.cnt_q !== 4'd0) begin fails++; $display("FAIL rstmid_cnt: got %0d want 0", dut.cnt_q); end
        clr(); run(16);
        tests++; if (ps_first != 16) begin fails++; $display("FAIL rstmid_restart: got first pulse at %0d want 16", ps_first); end
        tests++; if (cyc_diff != 0) begin fails++; $display("FAIL rstmid_model: got %0d differing cycles want 0", cyc_diff); end
    endtask

    task automatic test_random();
        cyc_diff = 0;
        for (int k = 0; k < 3000; k++) begin
            bus.ena      = ($urandom_range(0, 99) < 95);
            bus.prescale = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) bus.center = ~bus.center;
            bus.wr_en    = ($urandom_range(0, 9) == 0);
            bus.wr_ch    = 2'($urandom_range(0, 3));
            bus.wr_duty  = 4'($urandom_range(0, 15));
            step();
        end
        bus.wr_en = 1'b0;
        tests++; if (cyc_diff != 0) begin fails++; $display("FAIL random_model: got %0d differing cycles want 0", cyc_diff); end
    endtask

    initial begin
        test_reset();
        test_edge_duty();
        test_double_buffer();
        test_center();
        test_prescale();
        test_disable();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
